decay_scheduler: RTL and testbench

- Per-timestep sequencer for LIF membrane-potential decay across a bank of NUM_NEURONS neurons.
- On each timestep_start it walks every neuron address in order: read the float32 potential from the potential memory, scale it by the neuron's configured decay rate, write it back.
- Holds the per-neuron decay-rate table and the global model select.
- Sits between the timestep generator and the shared potential memory, replacing per-neuron free-running decay logic.

---
 rtl/decay_pkg.sv | 33 +++
 rtl/decay_scheduler_fp_exp_shift.sv | 28 ++
 rtl/decay_scheduler.sv | 113 +++++++++++
 tb/tb_decay_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decay_pkg.sv
// rtl/decay_pkg.sv - shared constants for the LIF decay scheduler and its exponent-shift unit
package decay_pkg;

  localparam logic [3:0] RATE_DIV1 = 4'b0001;
  localparam logic [3:0] RATE_DIV2 = 4'b0010;
  localparam logic [3:0] RATE_DIV4 = 4'b0100;
  localparam logic [3:0] RATE_DIV8 = 4'b1000;

  localparam logic [1:0] MODEL_LIF = 2'b00;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DECAY = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam logic [7:0] EXP_MAX = 8'hff;

  // Unrecognised rate codes fall back to no decay.
  function automatic logic [1:0] rate_to_shift(input logic [3:0] rate);
    case (rate)
      RATE_DIV2: rate_to_shift = 2'd1;
      RATE_DIV4: rate_to_shift = 2'd2;
      RATE_DIV8: rate_to_shift = 2'd3;
      default:   rate_to_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/decay_scheduler_fp_exp_shift.sv
// rtl/decay_scheduler_fp_exp_shift.sv - divides a float32 by 2^shift via its exponent field
module fp_exp_shift
  import decay_pkg::*;
(
  input  logic [31:0] value,
  input  logic [1:0]  shift,
  output logic [31:0] result
);

  logic [7:0] exp_in;
  logic [7:0] shift_ext;

  assign exp_in    = value[EXP_MSB:EXP_LSB];
  assign shift_ext = {6'b0, shift};

  // Zero and denormal inputs fall into the flush branch since their exponent is 0.
  always_comb begin
    result = value;
    if (exp_in == EXP_MAX) begin
      result = value;
    end else if (exp_in <= shift_ext) begin
      result = {value[SIGN_BIT], 31'b0};
    end else begin
      result = {value[SIGN_BIT], exp_in - shift_ext, value[EXP_LSB-1:0]};
    end
  end

endmodule

// File: rtl/decay_scheduler.sv
// rtl/decay_scheduler.sv - per-timestep read/decay/write sweep over the neuron potential memory
module decay_scheduler
  import decay_pkg::*;
#(
  parameter int         NUM_NEURONS  = 20,
  parameter int         ADDR_W       = 5,
  parameter logic [3:0] DEFAULT_RATE = 4'b0010
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              timestep_start,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_rate,
  input  logic [1:0]        cfg_model,
  output logic              cfg_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        model_q;
  logic [31:0]       rd_q;
  logic [3:0]        rate_tab [NUM_NEURONS];
  logic [1:0]        cur_shift;
  logic [31:0]       shifted;
  logic              cfg_addr_ok;
  logic              idle;

  assign idle        = (state == ST_IDLE);
  assign busy        = !idle;
  assign cfg_addr_ok = 32'(cfg_addr) < NUM_NEURONS;
  assign cur_shift   = rate_to_shift(rate_tab[idx]);

  fp_exp_shift u_shift (
    .value  (rd_q),
    .shift  (cur_shift),
    .result (shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      model_q     <= MODEL_LIF;
      rd_q        <= '0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      cfg_err     <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) rate_tab[i] <= DEFAULT_RATE;
    end else begin
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      overrun   <= timestep_start && !idle;
      cfg_err   <= cfg_we && (!idle || !cfg_addr_ok);
      // A table write in the start cycle lands before the sweep reaches DECAY.
      if (cfg_we && idle && cfg_addr_ok) rate_tab[cfg_addr] <= cfg_rate;

      case (state)
        ST_IDLE: begin
          if (timestep_start) begin
            idx         <= '0;
            model_q     <= cfg_model;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= '0;
            state       <= ST_READ;
          end
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          rd_q  <= mem_rd_data;
          state <= ST_DECAY;
        end
        ST_DECAY: begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= idx;
          mem_wr_data <= (model_q == MODEL_LIF) ? shifted : rd_q;
          state       <= ST_WRITE;
        end
        ST_WRITE: begin
          if (idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx         <= idx + 1'b1;
            mem_rd_en   <= 1'b1;
            mem_rd_addr <= idx + 1'b1;
            state       <= ST_READ;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decay_scheduler.sv
// tb/tb_decay_scheduler.sv - scoreboard bench for decay_scheduler with a behavioural memory and decay model
module tb_decay_scheduler;

  localparam int N  = 20;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          timestep_start = 1'b0;
  logic          busy, done, overrun, cfg_err;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [3:0]    cfg_rate = '0;
  logic [1:0]    cfg_model = 2'b00;
  logic          mem_rd_en, mem_wr_en;
  logic [AW-1:0] mem_rd_addr, mem_wr_addr;
  logic [31:0]   mem_rd_data = '0;
  logic [31:0]   mem_wr_data;

  always #5 clk = ~clk;

  decay_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW), .DEFAULT_RATE(4'b0010)) dut (
    .clk(clk), .rst(rst), .timestep_start(timestep_start), .busy(busy), .done(done),
    .overrun(overrun), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_rate(cfg_rate),
    .cfg_model(cfg_model), .cfg_err(cfg_err), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data)
  );

  logic [31:0]      mem [N];
  int               rate_m [N];
  logic [AW+31:0]   exp_wr_q [$];
  int               exp_done_q [$];
  int               cyc = 0;
  int               checks = 0;
  int               failures = 0;
  int               overrun_cnt = 0;
  int               cfg_err_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  function automatic int code_to_shift(input logic [3:0] r);
    case (r)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  // Dividing by 2^s lowers the exponent by s; a result that would reach exponent 0 or below flushes to signed zero.
  function automatic logic [31:0] ref_decay(input logic [31:0] v, input int s);
    int e;
    e = int'(v[30:23]);
    if (e == 255) return v;
    if (e - s <= 0) return {v[31], 31'b0};
    return {v[31], 8'(e - s), v[22:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_mem(input logic [31:0] v);
    for (int i = 0; i < N; i++) mem[i] = v;
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) rate_m[i] = 1;
    exp_wr_q.delete();
    exp_done_q.delete();
  endtask

  task automatic cfg_write(input int a, input logic [3:0] r, input logic exp_err);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_rate = r;
    tick();
    cfg_we = 1'b0;
    chk("cfg_err", {31'b0, cfg_err}, {31'b0, exp_err});
    if (!exp_err) rate_m[a] = code_to_shift(r);
  endtask

  task automatic start_sweep();
    logic [31:0] v;
    timestep_start = 1'b1;
    for (int i = 0; i < N; i++) begin
      v = (cfg_model == 2'b00) ? ref_decay(mem[i], rate_m[i]) : mem[i];
      exp_wr_q.push_back({AW'(i), v});
    end
    exp_done_q.push_back(cyc + 81);
    tick();
    timestep_start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (exp_done_q.size() == 0 && exp_wr_q.size() == 0 && !busy) break;
      tick();
    end
    chk("sweep_timeout_done", 32'(exp_done_q.size()), 32'd0);
    chk("sweep_timeout_writes", 32'(exp_wr_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (!rst) begin
      if (mem_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_write", {31'b0, mem_wr_en}, 32'd0);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", 32'(mem_wr_addr), 32'(e[AW+31:32]));
          chk("wr_data", mem_wr_data, e[31:0]);
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) chk("unexpected_done", {31'b0, done}, 32'd0);
        else chk("done_latency", 32'(cyc), 32'(exp_done_q.pop_front()));
      end
      if (overrun) overrun_cnt++;
      if (cfg_err) cfg_err_cnt++;
    end
  end

  initial begin
    int ov0, ce0;
    logic [3:0] codes [5];
    codes[0] = 4'b0001; codes[1] = 4'b0010; codes[2] = 4'b0100; codes[3] = 4'b1000; codes[4] = 4'b0110;
    reset_model();
    fill_mem(32'h41deb852);
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
    chk("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
    chk("rst_wr_data", mem_wr_data, 32'd0);
    chk("rst_flags", {30'b0, overrun, cfg_err}, 32'd0);

    // Default rate halves every potential.
    start_sweep();
    wait_idle();

    cfg_write(3, 4'b1000, 1'b0);
    start_sweep();
    wait_idle();

    mem[0] = 32'h00800000; mem[1] = 32'h80800000; mem[2] = 32'h7f800000;
    start_sweep();
    wait_idle();

    cfg_model = 2'b01;
    fill_mem(32'h41deb852);
    start_sweep();
    wait_idle();
    cfg_model = 2'b00;

    // Start and config write arriving mid-sweep are both rejected.
    ov0 = overrun_cnt; ce0 = cfg_err_cnt;
    start_sweep();
    repeat (9) tick();
    timestep_start = 1'b1;
    tick();
    timestep_start = 1'b0;
    cfg_write(7, 4'b1000, 1'b1);
    wait_idle();
    chk("overrun_count", 32'(overrun_cnt - ov0), 32'd1);
    chk("cfg_err_count", 32'(cfg_err_cnt - ce0), 32'd1);
    cfg_write(N, 4'b0100, 1'b1);
    start_sweep();
    wait_idle();

    // Reset mid-sweep must abort writes and restore the default rates.
    cfg_write(5, 4'b1000, 1'b0);
    start_sweep();
    repeat (29) tick();
    rst = 1'b1;
    reset_model();
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (100) tick();
    start_sweep();
    wait_idle();

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0: mem[i] = {$urandom_range(0, 1) == 1, 8'($urandom_range(0, 3)), 23'($urandom)};
          1: mem[i] = {$urandom_range(0, 1) == 1, 8'hff, 23'($urandom_range(0, 1))};
          default: mem[i] = $urandom;
        endcase
      end
      for (int j = 0; j < 4; j++) cfg_write(int'($urandom_range(0, N - 1)), codes[$urandom_range(0, 4)], 1'b0);
      cfg_model = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      start_sweep();
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
